sc_reg_sequencer: RTL and testbench
===================================

SC_REG_SEQUENCER -- requirements
Module: SC_REG_SEQUENCER

Interface
REQ-001 SHALL have parameter HOLDOFF_CYCLES, default 4, cycles spent in HOLD after each operation (legal range 1..255).
REQ-002 SHALL have parameter COUNT_WIDTH, default 8, width of the load counter.
REQ-003 SHALL have port SC_REG_SEQUENCER_CLOCK_50, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port SC_REG_SEQUENCER_RESET_InLow, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port SC_REG_SEQUENCER_clear_InLow, input, 1, debounced clear request level, active-low.
REQ-006 SHALL have port SC_REG_SEQUENCER_load_InLow, input, 1, debounced load request level, active-low.
REQ-007 SHALL have port SC_REG_SEQUENCER_clear_OutLow, output, 1, one-cycle clear strobe to the general register, active-low.
REQ-008 SHALL have port SC_REG_SEQUENCER_load_OutLow, output, 1, one-cycle load strobe to the general register, active-low.
REQ-009 SHALL have port SC_REG_SEQUENCER_shiftenable_Out, output, 1, high lets the shift register advance; low freezes it.
REQ-010 SHALL have port SC_REG_SEQUENCER_busy_Out, output, 1, high whenever state is not IDLE.
REQ-011 SHALL have port SC_REG_SEQUENCER_loadcount_OutBUS, output, COUNT_WIDTH, count of completed loads (present only per REQ-029).

Function
REQ-012 SHALL register each request input once per clock; a press is input=0 with previous sample=1 (falling edge).
REQ-013 SHALL hold one pending flag per requester, set at the edge a press is detected and cleared when that request is serviced; further presses while pending merge.
REQ-014 SHALL implement states IDLE, CLEAR, FREEZE, LOAD, HOLD, with all outputs decoded from registered state.
REQ-015 IDLE: clear pending -> CLEAR; else load pending -> FREEZE; else stay.
REQ-016 CLEAR: clear_OutLow=0 for exactly one cycle, clear pending cleared, -> HOLD.
REQ-017 FREEZE: shiftenable_Out=0 for one cycle so the shifter data is stable, -> LOAD.
REQ-018 LOAD: load_OutLow=0 and shiftenable_Out=0 for exactly one cycle, load pending cleared, load counter +1, -> HOLD.
REQ-019 HOLD: remain exactly HOLDOFF_CYCLES cycles, then -> IDLE; presses during HOLD are captured as pending.
REQ-020 Latency: press detected at edge E with sequencer idle -> CLEAR state from edge E+1, or FREEZE from E+1 and LOAD from E+2.
REQ-021 Simultaneous clear and load presses SHALL service clear first; load stays pending and is serviced after HOLD.
REQ-022 clear_OutLow and load_OutLow SHALL never be low in the same cycle.
REQ-023 shiftenable_Out SHALL be 1 in IDLE, CLEAR and HOLD.
REQ-024 Load counter SHALL wrap from 2^COUNT_WIDTH-1 to 0.
REQ-025 A request held low continuously SHALL produce exactly one operation.

Reset
REQ-026 While RESET_InLow=0 at a clock edge: state=IDLE, pending flags=0, HOLD counter=0, load counter=0.
REQ-027 Reset values: clear_OutLow=1, load_OutLow=1, shiftenable_Out=1, busy_Out=0, loadcount_OutBUS=0.
REQ-028 Input sample registers SHALL reset to 1, so a button held low through reset needs release and re-press; reset mid-operation aborts it with no strobe afterward.

Configuration
REQ-029 Macro REG_SEQUENCER_LOADCOUNT_EN: defined -> load counter and loadcount_OutBUS exist per REQ-018/REQ-024; undefined -> no counter logic, loadcount_OutBUS driven constant 0.

Verification
REQ-030 Reset, then load low at cycle 10 -> FREEZE cycle 11 (shiftenable=0), load_OutLow=0 only in cycle 12, busy=1 cycles 11-16, IDLE cycle 17, loadcount=1.
REQ-031 Clear and load fall on the same edge -> clear_OutLow=0 one cycle, 4 HOLD cycles, then FREEZE, LOAD; never both strobes low together.
REQ-032 Load held low 100 cycles -> exactly one load strobe; release and re-press -> second strobe, loadcount=2.
REQ-033 Clear pressed during HOLD of a load -> clear strobe the cycle after HOLD ends +1; second clear press during same HOLD -> still one strobe.
REQ-034 Reset asserted in FREEZE -> next cycle IDLE, no load strobe, loadcount unchanged at 0, all outputs at reset values.
REQ-035 256 separate loads with REG_SEQUENCER_LOADCOUNT_EN defined -> loadcount wraps to 0; without macro -> loadcount stays 0 throughout.

Source files
------------

// File: rtl/sc_reg_sequencer.sv
// sc_reg_sequencer: sequences clear/load strobes to a general register and
// freezes the shift register around each load so the loaded data is stable.
// Two debounced active-low requesters are captured as falling-edge presses
// into pending flags; a five-state FSM services them, clear first.
// Optional feature macro: REG_SEQUENCER_LOADCOUNT_EN (adds the wrapping
// completed-load counter; otherwise loadcount_OutBUS is tied to zero).

// Per-requester capture: one input sample register plus a sticky pending
// flag. Sample resets to 1 so only a real 1->0 transition counts as a press.
module sc_req_capture (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic req_n_i,
  input  logic svc_i,
  output logic pend_o
);
  logic smp_q, smp_d;
  logic pend_q, pend_d;
  logic press;

  assign press = ~req_n_i & smp_q;
  assign smp_d = req_n_i;

  // A new press wins over a same-edge service so it is never lost.
  always_comb begin
    pend_d = pend_q;
    if (svc_i)  pend_d = 1'b0;
    if (press)  pend_d = 1'b1;
  end

  // Sample and pending registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      smp_q  <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      smp_q  <= smp_d;
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;
endmodule

module sc_reg_sequencer #(
  parameter int HOLDOFF_CYCLES = 4,
  parameter int COUNT_WIDTH    = 8
) (
  input  logic                   SC_REG_SEQUENCER_CLOCK_50,
  input  logic                   SC_REG_SEQUENCER_RESET_InLow,
  input  logic                   SC_REG_SEQUENCER_clear_InLow,
  input  logic                   SC_REG_SEQUENCER_load_InLow,
  output logic                   SC_REG_SEQUENCER_clear_OutLow,
  output logic                   SC_REG_SEQUENCER_load_OutLow,
  output logic                   SC_REG_SEQUENCER_shiftenable_Out,
  output logic                   SC_REG_SEQUENCER_busy_Out,
  output logic [COUNT_WIDTH-1:0] SC_REG_SEQUENCER_loadcount_OutBUS
);
  localparam int NUM_REQ = 2;
  localparam int REQ_CLR = 0;
  localparam int REQ_LD  = 1;
  localparam int HOLD_W  = 8;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FREEZE = 3'd2,
    S_LOAD   = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  // Decoded output bundle, all bits derived from registered state only.
  typedef struct packed {
    logic clr_n;
    logic ld_n;
    logic se;
    logic busy;
  } seq_out_t;

  logic clk, rst_n;
  assign clk   = SC_REG_SEQUENCER_CLOCK_50;
  assign rst_n = SC_REG_SEQUENCER_RESET_InLow;

  logic [NUM_REQ-1:0] req_n;
  logic [NUM_REQ-1:0] svc;
  logic [NUM_REQ-1:0] pend;

  assign req_n[REQ_CLR] = SC_REG_SEQUENCER_clear_InLow;
  assign req_n[REQ_LD]  = SC_REG_SEQUENCER_load_InLow;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    sc_req_capture u_cap (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .req_n_i (req_n[g]),
      .svc_i   (svc[g]),
      .pend_o  (pend[g])
    );
  end

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  seq_out_t          outs;

  // Next-state logic; service strobes to the capture units leave with the
  // state that performed the operation.
  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    svc     = '0;
    case (state_q)
      S_IDLE: begin
        if (pend[REQ_CLR])     state_d = S_CLEAR;
        else if (pend[REQ_LD]) state_d = S_FREEZE;
      end
      S_CLEAR: begin
        svc[REQ_CLR] = 1'b1;
        state_d      = S_HOLD;
      end
      S_FREEZE: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        svc[REQ_LD] = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = S_IDLE;
        else                     hold_d  = hold_q + HOLD_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and hold-off counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Output decode; the two strobes come from distinct states so they can
  // never be low together.
  always_comb begin
    outs.clr_n = (state_q != S_CLEAR);
    outs.ld_n  = (state_q != S_LOAD);
    outs.se    = !((state_q == S_FREEZE) || (state_q == S_LOAD));
    outs.busy  = (state_q != S_IDLE);
  end

  assign SC_REG_SEQUENCER_clear_OutLow    = outs.clr_n;
  assign SC_REG_SEQUENCER_load_OutLow     = outs.ld_n;
  assign SC_REG_SEQUENCER_shiftenable_Out = outs.se;
  assign SC_REG_SEQUENCER_busy_Out        = outs.busy;

`ifdef REG_SEQUENCER_LOADCOUNT_EN
  logic [COUNT_WIDTH-1:0] lcnt_q, lcnt_d;

  assign lcnt_d = (state_q == S_LOAD) ? lcnt_q + COUNT_WIDTH'(1) : lcnt_q;

  // Completed-load counter, wraps naturally at 2^COUNT_WIDTH.
  always_ff @(posedge clk) begin
    if (!rst_n) lcnt_q <= '0;
    else        lcnt_q <= lcnt_d;
  end

  assign SC_REG_SEQUENCER_loadcount_OutBUS = lcnt_q;
`else
  assign SC_REG_SEQUENCER_loadcount_OutBUS = '0;
`endif

endmodule

// File: tb/tb_sc_reg_sequencer.sv
// Bench for sc_reg_sequencer: directed scenarios plus randomized request
// traffic, every cycle compared against a schedule-based reference model.
module tb_sc_reg_sequencer;
  localparam int HOLD = 4;
  localparam int CW   = 8;
`ifdef REG_SEQUENCER_LOADCOUNT_EN
  localparam bit LC_EN = 1'b1;
`else
  localparam bit LC_EN = 1'b0;
`endif

  // Output vector {clr_n, ld_n, se, busy}
  localparam logic [3:0] O_IDLE = 4'b1110;
  localparam logic [3:0] O_CLR  = 4'b0111;
  localparam logic [3:0] O_FRZ  = 4'b1101;
  localparam logic [3:0] O_LD   = 4'b1001;
  localparam logic [3:0] O_HOLD = 4'b1111;

  logic clk = 1'b0;
  logic rst_n, clr_in, ld_in;
  logic clr_o, ld_o, se_o, busy_o;
  logic [CW-1:0] lc_o;

  int checks = 0;
  int errors = 0;
  int n_clr  = 0;
  int n_ld   = 0;

  // reference model state
  logic [3:0] m_q[$];
  logic [3:0] m_cur = O_IDLE;
  logic m_pc = 1'b0, m_pl = 1'b0, m_prev_c = 1'b1, m_prev_l = 1'b1;
  int   m_cnt = 0;

  sc_reg_sequencer #(.HOLDOFF_CYCLES(HOLD), .COUNT_WIDTH(CW)) dut (
    .SC_REG_SEQUENCER_CLOCK_50        (clk),
    .SC_REG_SEQUENCER_RESET_InLow     (rst_n),
    .SC_REG_SEQUENCER_clear_InLow     (clr_in),
    .SC_REG_SEQUENCER_load_InLow      (ld_in),
    .SC_REG_SEQUENCER_clear_OutLow    (clr_o),
    .SC_REG_SEQUENCER_load_OutLow     (ld_o),
    .SC_REG_SEQUENCER_shiftenable_Out (se_o),
    .SC_REG_SEQUENCER_busy_Out        (busy_o),
    .SC_REG_SEQUENCER_loadcount_OutBUS(lc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: each accepted request schedules its whole output sequence;
  // pending flags follow press / service rules directly.
  task automatic model_step();
    logic [3:0] old;
    logic pc, pl, old_pc, old_pl;
    old = m_cur;
    if (!rst_n) begin
      m_q.delete();
      m_pc = 1'b0; m_pl = 1'b0; m_prev_c = 1'b1; m_prev_l = 1'b1;
      m_cnt = 0; m_cur = O_IDLE;
      return;
    end
    pc = !clr_in && m_prev_c;
    pl = !ld_in  && m_prev_l;
    m_prev_c = clr_in;
    m_prev_l = ld_in;
    old_pc = m_pc;
    old_pl = m_pl;
    if (old == O_CLR) m_pc = 1'b0;
    if (old == O_LD) begin m_pl = 1'b0; m_cnt = (m_cnt + 1) % (1 << CW); end
    if (pc) m_pc = 1'b1;
    if (pl) m_pl = 1'b1;
    if (m_q.size() == 0 && old == O_IDLE) begin
      if (old_pc) begin
        m_q.push_back(O_CLR);
        repeat (HOLD) m_q.push_back(O_HOLD);
      end else if (old_pl) begin
        m_q.push_back(O_FRZ);
        m_q.push_back(O_LD);
        repeat (HOLD) m_q.push_back(O_HOLD);
      end
    end
    m_cur = (m_q.size() > 0) ? m_q.pop_front() : O_IDLE;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk({tag, "/clr"},  clr_o,  m_cur[3]);
    chk({tag, "/ld"},   ld_o,   m_cur[2]);
    chk({tag, "/se"},   se_o,   m_cur[1]);
    chk({tag, "/busy"}, busy_o, m_cur[0]);
    chk({tag, "/lc"},   lc_o,   LC_EN ? m_cnt : 0);
    chk({tag, "/excl"}, clr_o | ld_o, 1);
    if (!clr_o) n_clr++;
    if (!ld_o)  n_ld++;
  endtask

  initial begin
    int base;
    rst_n = 1'b0; clr_in = 1'b1; ld_in = 1'b1;
    repeat (3) step("rst");
    chk("rst_clr", clr_o, 1); chk("rst_ld", ld_o, 1);
    chk("rst_se", se_o, 1);   chk("rst_busy", busy_o, 0);
    chk("rst_lc", lc_o, 0);
    rst_n = 1'b1;
    repeat (5) step("idle");

    // single load: FREEZE at E+1, LOAD at E+2, HOLD E+3..E+6, IDLE E+7
    ld_in = 1'b0; step("l_e");
    chk("l_e_busy", busy_o, 0);
    ld_in = 1'b1; step("l_frz");
    chk("l_frz_se", se_o, 0); chk("l_frz_ld", ld_o, 1); chk("l_frz_busy", busy_o, 1);
    step("l_ld");
    chk("l_ld_ld", ld_o, 0); chk("l_ld_se", se_o, 0);
    for (int i = 0; i < HOLD; i++) begin
      step("l_hold");
      chk("l_hold_busy", busy_o, 1); chk("l_hold_se", se_o, 1); chk("l_hold_ld", ld_o, 1);
    end
    step("l_idle");
    chk("l_idle_busy", busy_o, 0); chk("l_idle_lc", lc_o, LC_EN ? 1 : 0);

    // simultaneous presses: clear first, then load after HOLD + IDLE
    clr_in = 1'b0; ld_in = 1'b0; step("s_e");
    clr_in = 1'b1; ld_in = 1'b1; step("s_clr");
    chk("s_clr_clr", clr_o, 0); chk("s_clr_ld", ld_o, 1);
    repeat (HOLD) step("s_hold");
    step("s_idle"); chk("s_idle_busy", busy_o, 0);
    step("s_frz");  chk("s_frz_se", se_o, 0);
    step("s_ld");   chk("s_ld_ld", ld_o, 0); chk("s_ld_clr", clr_o, 1);
    repeat (HOLD + 1) step("s_tail");

    // held low 100 cycles -> one load; re-press -> second
    base = n_ld;
    ld_in = 1'b0; repeat (100) step("h_low");
    ld_in = 1'b1; repeat (5) step("h_rel");
    chk("h_one", n_ld - base, 1);
    ld_in = 1'b0; step("h_re");
    ld_in = 1'b1; repeat (10) step("h_re2");
    chk("h_two", n_ld - base, 2);
    chk("h_lc", lc_o, LC_EN ? 4 : 0);

    // clear presses during a load's HOLD merge into one strobe after IDLE
    base = n_clr;
    ld_in = 1'b0; step("c_e");
    ld_in = 1'b1; step("c_frz"); step("c_ld"); step("c_h0");
    clr_in = 1'b0; step("c_p1");
    clr_in = 1'b1; step("c_r1");
    clr_in = 1'b0; step("c_p2");
    chk("c_p2_busy", busy_o, 1);
    clr_in = 1'b1; step("c_idle");
    chk("c_idle_busy", busy_o, 0); chk("c_idle_clr", clr_o, 1);
    step("c_clr"); chk("c_clr_clr", clr_o, 0);
    repeat (10) step("c_tail");
    chk("c_one", n_clr - base, 1);

    // reset during FREEZE aborts the load
    base = n_ld;
    ld_in = 1'b0; step("r_e");
    ld_in = 1'b1; step("r_frz"); chk("r_frz_se", se_o, 0);
    rst_n = 1'b0; step("r_rst");
    chk("r_rst_se", se_o, 1); chk("r_rst_busy", busy_o, 0);
    chk("r_rst_ld", ld_o, 1); chk("r_rst_lc", lc_o, 0);
    rst_n = 1'b1; repeat (10) step("r_after");
    chk("r_noload", n_ld - base, 0); chk("r_lc", lc_o, 0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0; clr_in = 1'b1; ld_in = 1'b1;
        step("rnd_rst"); step("rnd_rst");
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 5) == 0) clr_in = ~clr_in;
      if ($urandom_range(0, 4) == 0) ld_in  = ~ld_in;
      step("rnd");
    end
    clr_in = 1'b1; ld_in = 1'b1;

    // 256 loads from reset -> counter wraps to 0
    rst_n = 1'b0; step("w_rst"); step("w_rst");
    rst_n = 1'b1; step("w_idle");
    for (int i = 0; i < 256; i++) begin
      ld_in = 1'b0; step("w_e");
      ld_in = 1'b1; repeat (8) step("w_op");
      if (i == 254) chk("w_255", lc_o, LC_EN ? 255 : 0);
    end
    chk("w_wrap", lc_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
